// File: rtl/sap_pkg.sv
// Shared types and widths for the SAP memory subsystem.
// Bus payloads used by the arbiter and the requesters that sit around it.
package sap_pkg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // One latched RAM access: direction, address and write payload.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sap_rr_pick2.sv
// Combinational 2-way round-robin picker with a lock override for requester 1.
// Output is one-hot, or zero when nobody requests.
module sap_rr_pick2 (
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       last,
    output logic [1:0] gnt
);

    // last = index of the previous winner; on contention the other index wins.
    always_comb begin
        gnt = 2'b00;
        if (lock && req[1]) begin
            gnt = 2'b10;
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sap_mem_arbiter.sv
// Arbiter/sequencer sharing the SAP single-port 16x8 RAM between the CPU
// memory port and the host loader/debug port.
module sap_mem_arbiter
    import sap_pkg::*;
(
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, last_q, win;
    mem_req_t   req_q, req_d;
    logic [1:0] pick;
    logic       accept;
    logic       en_q;
    logic       cpu_rvalid_q, host_rvalid_q;
    logic [DW-1:0] cpu_rdata_q, host_rdata_q;

    sap_rr_pick2 u_pick (
        .req  ({host_valid, cpu_req}),
        .lock (host_lock),
        .last (last_q == OWN_HOST),
        .gnt  (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept handshakes and the request to latch.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        win        = OWN_CPU;
        req_d      = req_q;
        cpu_gnt    = 1'b0;
        host_ready = 1'b0;
        cpu_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst && (pick != 2'b00)) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                    win     = pick[1] ? OWN_HOST : OWN_CPU;
                end
            end
            ACCESS:  state_d = req_q.we ? IDLE : RDWAIT;
            RDWAIT:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (win == OWN_HOST) begin
            req_d.we    = host_we;
            req_d.addr  = host_addr;
            req_d.wdata = host_wdata;
        end else begin
            req_d.we    = cpu_we;
            req_d.addr  = cpu_addr;
            req_d.wdata = cpu_wdata;
        end

        cpu_gnt    = accept && (win == OWN_CPU);
        host_ready = accept && (win == OWN_HOST);
        cpu_stall  = cpu_req && !cpu_gnt && !rst;
    end

    // Request latches, fairness pointer and RAM strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_CPU;
            last_q  <= OWN_HOST;
            req_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= accept;
            if (accept) begin
                owner_q <= win;
                last_q  <= win;
                req_q   <= req_d;
            end
        end
    end

    // Read return path: capture in RDWAIT, pulse rvalid during RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= (state_q == RDWAIT) && (owner_q == OWN_CPU);
            host_rvalid_q <= (state_q == RDWAIT) && (owner_q == OWN_HOST);
            if (state_q == RDWAIT) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_q <= ram_rdata;
                end else begin
                    host_rdata_q <= ram_rdata;
                end
            end
        end
    end

    // Reset in the ACCESS cycle must keep the strobe off so the write is dropped.
    assign ram_en      = en_q && !rst;
    assign ram_we      = en_q && req_q.we && !rst;
    assign ram_addr    = req_q.addr;
    assign ram_wdata   = req_q.wdata;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// Directed bench for sap_mem_arbiter with a behavioural synchronous 16x8 RAM.
module tb_sap_mem_arbiter;
    import sap_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_valid, host_we, host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [16];
    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    always #5 clk = ~clk;

    sap_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_valid  (host_valid),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        host_lock = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Every 1-bit output packed together; expected all-zero after reset.
    function automatic logic [7:0] flags();
        return 8'({cpu_gnt, host_ready, cpu_stall, cpu_rvalid, host_rvalid, ram_en, ram_we});
    endfunction

    initial begin
        int cc, hc, gnt_cycle, hc_at, wr0;
        rst = 1'b1;
        idle_inputs();

        // Reset state, then CPU write 0x5A to addr 3 and read it back.
        do_reset();
        @(negedge clk); #1;
        check_eq("rst_flags", flags(), 8'h00);
        check_eq("rst_cpu_rdata", cpu_rdata, 8'h00);
        check_eq("rst_host_rdata", host_rdata, 8'h00);
        check_eq("rst_ram_addr", 8'(ram_addr), 8'h00);
        check_eq("rst_ram_wdata", ram_wdata, 8'h00);
        wr0 = wr_cnt;

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'h5A;
        #1;
        check_eq("t1_wr_gnt", 8'(cpu_gnt), 8'd1);
        check_eq("t1_wr_ready", 8'(host_ready), 8'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check_eq("t1_ram_en", 8'(ram_en), 8'd1);
        check_eq("t1_ram_we", 8'(ram_we), 8'd1);
        check_eq("t1_ram_addr", 8'(ram_addr), 8'd3);
        check_eq("t1_ram_wdata", ram_wdata, 8'h5A);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        #1;
        check_eq("t1_rd_gnt", 8'(cpu_gnt), 8'd1);
        check_eq("t1_rd_en_idle", 8'(ram_en), 8'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check_eq("t1_rd_en", 8'(ram_en), 8'd1);
        check_eq("t1_rd_we", 8'(ram_we), 8'd0);
        check_eq("t1_rv_t1", 8'(cpu_rvalid), 8'd0);
        @(negedge clk); #1;
        check_eq("t1_rv_t2", 8'(cpu_rvalid), 8'd0);
        @(negedge clk); #1;
        check_eq("t1_rv_t3", 8'(cpu_rvalid), 8'd1);
        check_eq("t1_rdata", cpu_rdata, 8'h5A);
        check_eq("t1_host_rv", 8'(host_rvalid), 8'd0);
        @(negedge clk); #1;
        check_eq("t1_rv_t4", 8'(cpu_rvalid), 8'd0);
        check_eq("t1_rdata_hold", cpu_rdata, 8'h5A);
        check_eq("t1_wr_count", 8'(wr_cnt - wr0), 8'd1);

        // Contention: both request writes from the same cycle, four each.
        do_reset();
        cc = 0; hc = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            cpu_req    = (cc < 4); cpu_we = 1'b1;
            cpu_addr   = AW'(8 + cc); cpu_wdata = DW'(8'hA0 + cc);
            host_valid = (hc < 4); host_we = 1'b1;
            host_addr  = AW'(12 + hc); host_wdata = DW'(8'hB0 + hc);
            #1;
            check_eq($sformatf("t2_cgnt_c%0d", c), 8'(cpu_gnt), 8'((c % 4 == 0) && (c <= 12)));
            check_eq($sformatf("t2_hrdy_c%0d", c), 8'(host_ready), 8'((c % 4 == 2) && (c <= 14)));
            check_eq($sformatf("t2_stall_c%0d", c), 8'(cpu_stall), 8'((c < 13) && (c % 4 != 0)));
            if (cpu_gnt) cc++;
            if (host_ready) hc++;
        end
        @(negedge clk);
        idle_inputs();
        check_eq("t2_cpu_grants", 8'(cc), 8'd4);
        check_eq("t2_host_grants", 8'(hc), 8'd4);

        // Locked host burst of 16 writes while the CPU waits to read addr 7.
        hc = 0; gnt_cycle = -1; hc_at = -1;
        for (int c = 0; c < 60 && gnt_cycle < 0; c++) begin
            @(negedge clk);
            host_valid = (hc < 16); host_lock = (hc < 16); host_we = 1'b1;
            host_addr  = AW'(hc); host_wdata = DW'(hc + 16);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
            #1;
            if (host_ready) hc++;
            if (cpu_gnt) begin
                gnt_cycle = c;
                hc_at     = hc;
            end
        end
        check_eq("t3_host_done_first", 8'(hc_at), 8'd16);
        check_eq("t3_cpu_gnt_cycle", 8'(gnt_cycle), 8'd32);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t3_rv", 8'(cpu_rvalid), 8'd1);
        check_eq("t3_rdata", cpu_rdata, 8'h17);

        // Reset during ACCESS of a host write drops the write.
        @(negedge clk);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 4'd9; host_wdata = 8'hFF;
        #1;
        check_eq("t4_ready", 8'(host_ready), 8'd1);
        @(negedge clk);
        host_valid = 1'b0; rst = 1'b1;
        #1;
        check_eq("t4_en_in_rst", 8'(ram_en), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t4_flags", flags(), 8'h00);
        check_eq("t4_ram_addr", 8'(ram_addr), 8'd0);
        check_eq("t4_ram_wdata", ram_wdata, 8'h00);
        check_eq("t4_cpu_rdata", cpu_rdata, 8'h00);
        check_eq("t4_host_rdata", host_rdata, 8'h00);
        check_eq("t4_mem9", mem[9], 8'h19);
        @(negedge clk);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 4'd9;
        #1;
        check_eq("t4_idle_ready", 8'(host_ready), 8'd1);
        @(negedge clk);
        host_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t4_host_rv", 8'(host_rvalid), 8'd1);
        check_eq("t4_host_rdata", host_rdata, 8'h19);
        check_eq("t4_cpu_rv", 8'(cpu_rvalid), 8'd0);

        // Reset during RDWAIT of a CPU read suppresses the response.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        #1;
        check_eq("t5_gnt", 8'(cpu_gnt), 8'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t5_rv_a", 8'(cpu_rvalid), 8'd0);
        check_eq("t5_rdata", cpu_rdata, 8'h00);
        @(negedge clk); #1;
        check_eq("t5_rv_b", 8'(cpu_rvalid), 8'd0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        #1;
        check_eq("t5_gnt2", 8'(cpu_gnt), 8'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t5_rv2", 8'(cpu_rvalid), 8'd1);
        check_eq("t5_rdata2", cpu_rdata, 8'h17);

        // Host write and CPU read of addr 4 together; CPU was granted last.
        @(negedge clk);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 4'd4; host_wdata = 8'hC3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd4;
        #1;
        check_eq("t6_host_first", 8'(host_ready), 8'd1);
        check_eq("t6_cpu_wait", 8'(cpu_gnt), 8'd0);
        check_eq("t6_stall_a", 8'(cpu_stall), 8'd1);
        @(negedge clk);
        host_valid = 1'b0;
        #1;
        check_eq("t6_gnt_busy", 8'(cpu_gnt), 8'd0);
        check_eq("t6_stall_b", 8'(cpu_stall), 8'd1);
        check_eq("t6_wr_we", 8'(ram_we), 8'd1);
        check_eq("t6_wr_addr", 8'(ram_addr), 8'd4);
        @(negedge clk); #1;
        check_eq("t6_cpu_gnt", 8'(cpu_gnt), 8'd1);
        check_eq("t6_stall_c", 8'(cpu_stall), 8'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t6_rv", 8'(cpu_rvalid), 8'd1);
        check_eq("t6_rdata", cpu_rdata, 8'hC3);
        check_eq("t6_host_rv", 8'(host_rvalid), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
